rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 16384, giving the maximum words accepted (matches RAM16K program store).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin a load session.
REQ-005 SHALL have port abort, input, 1, cancels an active session.
REQ-006 SHALL have port byte_in, input, 8, incoming stream byte.
REQ-007 SHALL have port byte_valid, input, 1, byte_in is valid.
REQ-008 SHALL have port byte_ready, output, 1, loader can accept a byte.
REQ-009 SHALL have port rom_addr, output, 15, program-store write address (drives ROMAddressLineCtl).
REQ-010 SHALL have port rom_data, output, 16, program-store write data (drives ROMDataLine).
REQ-011 SHALL have port rom_load, output, 1, single-cycle write strobe to program store.
REQ-012 SHALL have port cpu_hold, output, 1, high for the whole session; holds the CPU in reset.
REQ-013 SHALL have port done, output, 1, session completed successfully (level).
REQ-014 SHALL have port error, output, 1, session rejected (level).
REQ-015 SHALL have port words_loaded, output, 15, number of words written this session.

Function
REQ-016 SHALL implement states IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR.
REQ-017 SHALL accept a byte only on a rising edge where byte_valid and byte_ready are both 1.
REQ-018 SHALL drive byte_ready=1 only in CNT_HI, CNT_LO, DAT_HI, DAT_LO; 0 otherwise.
REQ-019 SHALL treat the stream as: 16-bit word count N (high byte first), then N words (high byte first).
REQ-020 SHALL move IDLE/DONE/ERROR -> CNT_HI on start=1, clearing done, error, words_loaded.
REQ-021 SHALL ignore start while in CNT_HI..WRITE.
REQ-022 SHALL on CNT_LO byte acceptance go to DONE if N=0, to ERROR if N>ROM_DEPTH, else DAT_HI; no write occurs in the first two cases.
REQ-023 SHALL on DAT_HI acceptance latch the high byte and go to DAT_LO.
REQ-024 SHALL on DAT_LO acceptance go to WRITE; in WRITE rom_data={high,low}, rom_addr=words_loaded, rom_load=1 for exactly one cycle.
REQ-025 SHALL on leaving WRITE increment words_loaded; go to DONE if new value equals N, else DAT_HI.
REQ-026 SHALL keep rom_addr and rom_data stable for the whole rom_load=1 cycle; rom_load=0 in every other state.
REQ-027 SHALL drive cpu_hold=1 in CNT_HI..WRITE, 0 in IDLE, DONE, ERROR.
REQ-028 SHALL latency: rom_load asserts the cycle after the low data byte is accepted; minimum 3 cycles per word.
REQ-029 SHALL on abort=1 in CNT_HI..WRITE go to IDLE next edge with no further write; abort takes priority over a simultaneous byte acceptance or write.
REQ-030 SHALL ignore abort in IDLE, DONE, ERROR.
REQ-031 SHALL permit N=ROM_DEPTH; final write at address ROM_DEPTH-1, words_loaded=ROM_DEPTH (wraps to 0 in 15 bits when ROM_DEPTH=32768; completion compares against the internal 16-bit count).
REQ-032 SHALL hold done=1 only in DONE and error=1 only in ERROR.

Reset
REQ-033 SHALL on rst=0 immediately enter IDLE: rom_load=0, cpu_hold=0, byte_ready=0, done=0, error=0, words_loaded=0, rom_addr=0, rom_data=0.
REQ-034 SHALL on reset mid-session abandon all partial bytes; no write may occur while rst=0.

Verification
REQ-035 SHALL test: start, bytes 00 02 12 34 AB CD -> rom_load pulses at addr 0 data 1234 then addr 1 data ABCD; done=1, words_loaded=2, cpu_hold falls.
REQ-036 SHALL test: start, bytes 00 00 -> DONE, no rom_load pulse, words_loaded=0.
REQ-037 SHALL test: start, bytes 40 01 (N=16385) -> error=1, no rom_load pulse, byte_ready=0.
REQ-038 SHALL test: abort asserted after 00 02 12 -> IDLE, no write, cpu_hold=0; next session starts cleanly.
REQ-039 SHALL test: rst=0 during DAT_LO of word 1 -> outputs at reset values asynchronously; new start reloads from address 0.
REQ-040 SHALL test: byte_valid toggled randomly with byte_ready back-pressure -> identical write sequence to REQ-035.

Source files
------------

// File: rtl/rom_loader.sv
// Byte-stream program-store loader: receives a 16-bit word count and then that
// many big-endian 16-bit words, and writes them to the program store while the CPU is held in reset.
module rom_loader #(
  parameter int ROM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        rom_load,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [14:0] words_loaded
);

  // state  | meaning
  // IDLE   | no session, waiting for start
  // CNT_HI | expecting high byte of word count N
  // CNT_LO | expecting low byte of N, then range check
  // DAT_HI | expecting high byte of next data word
  // DAT_LO | expecting low byte of next data word
  // WRITE  | one-cycle write strobe to the program store
  // DONE   | all N words written
  // ERROR  | N exceeded ROM_DEPTH
  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(ROM_DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_n;
  logic [15:0] r_count;
  logic [7:0]  r_hi;
  logic [14:0] r_rom_addr;
  logic [15:0] r_rom_data;
  logic        r_rom_load;
  logic        r_byte_ready;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic        w_active;
  logic        w_abort;
  logic [15:0] w_count_inc;
  logic [15:0] w_n_rx;

  assign w_accept    = byte_valid & r_byte_ready;
  assign w_active    = r_state inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE};
  assign w_abort     = w_active & abort;
  assign w_count_inc = r_count + 16'd1;
  assign w_n_rx      = {r_n[15:8], byte_in};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE, ERROR: if (start) w_state_nxt = CNT_HI;
      CNT_HI: if (w_accept) w_state_nxt = CNT_LO;
      CNT_LO: begin
        if (w_accept) begin
          if (w_n_rx == 16'd0)                 w_state_nxt = DONE;
          else if ({1'b0, w_n_rx} > LP_DEPTH)  w_state_nxt = ERROR;
          else                                 w_state_nxt = DAT_HI;
        end
      end
      DAT_HI: if (w_accept) w_state_nxt = DAT_LO;
      DAT_LO: if (w_accept) w_state_nxt = WRITE;
      WRITE:  w_state_nxt = (w_count_inc == r_n) ? DONE : DAT_HI;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_count      <= '0;
      r_hi         <= '0;
      r_rom_addr   <= '0;
      r_rom_data   <= '0;
      r_rom_load   <= 1'b0;
      r_byte_ready <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_ready <= w_state_nxt inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO};
      r_cpu_hold   <= w_state_nxt inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE};
      r_rom_load   <= (w_state_nxt == WRITE);
      r_done       <= (w_state_nxt == DONE);
      r_error      <= (w_state_nxt == ERROR);
      if (!w_abort) begin
        case (r_state)
          IDLE, DONE, ERROR: if (start) r_count <= '0;
          CNT_HI: if (w_accept) r_n[15:8] <= byte_in;
          CNT_LO: if (w_accept) r_n[7:0]  <= byte_in;
          DAT_HI: if (w_accept) r_hi      <= byte_in;
          DAT_LO: begin
            if (w_accept) begin
              r_rom_data <= {r_hi, byte_in};
              r_rom_addr <= r_count[14:0];
            end
          end
          WRITE:   r_count <= w_count_inc;
          default: ;
        endcase
      end
    end
  end

  // An abort arriving in the WRITE cycle suppresses the strobe already in flight.
  assign rom_load     = r_rom_load & ~abort;
  assign byte_ready   = r_byte_ready;
  assign rom_addr     = r_rom_addr;
  assign rom_data     = r_rom_data;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_count[14:0];

endmodule

// File: tb/tb_rom_loader.sv
// Directed and randomized sessions for rom_loader, checked against a stream-level
// model that derives the expected program-store writes from the byte sequence.
module tb_rom_loader;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_load;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [14:0] words_loaded;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  stream[$];
  logic [30:0] obs_q[$];
  logic [30:0] exp_q[$];
  logic        exp_done;
  logic        exp_err;
  logic [14:0] exp_words;

  rom_loader #(.ROM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_load(rom_load),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && rom_load) obs_q.push_back({rom_addr, rom_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the byte stream means, independent of how it is received.
  task automatic model_stream();
    int n;
    exp_q.delete();
    n = {stream[0], stream[1]};
    exp_done = 1'b0; exp_err = 1'b0; exp_words = '0;
    if (n == 0) exp_done = 1'b1;
    else if (n > DEPTH) exp_err = 1'b1;
    else begin
      exp_done = 1'b1;
      exp_words = 15'(n);
      for (int i = 0; i < n; i++)
        exp_q.push_back({15'(i), stream[2 + 2*i], stream[3 + 2*i]});
    end
  endtask

  task automatic start_session();
    obs_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_stream(input bit rnd);
    int idx = 0;
    int cyc = 0;
    while (idx < stream.size() && cyc < 2000) begin
      @(negedge clk);
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in = byte_valid ? stream[idx] : 8'($urandom);
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (byte_valid && byte_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b0;
    check("stream_bytes_accepted", 32'(idx), 32'(stream.size()));
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(done || error) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("session_end_in_time", 32'(c < 200), 32'd1);
  endtask

  task automatic compare_session(input string tag);
    check({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic run_session(input string tag, input bit rnd);
    model_stream();
    start_session();
    check({tag, "_hold_on_start"}, 32'(cpu_hold), 32'd1);
    send_stream(rnd);
    wait_end();
    repeat (2) @(negedge clk);
    compare_session(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_load"}, 32'(rom_load), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    check({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_data"}, 32'(rom_data), 32'd0);
  endtask

  initial begin
    int n;
    #1 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_session("two_words", 1'b0);

    stream = '{8'h00, 8'h00};
    run_session("zero_count", 1'b0);

    stream = '{8'h40, 8'h01};
    run_session("over_depth", 1'b0);

    // Abort in DAT_LO of the first word.
    stream = '{8'h00, 8'h02, 8'h12};
    start_session();
    send_stream(1'b0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_hold", 32'(cpu_hold), 32'd0);
    check("abort_ready", 32'(byte_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_nwrites", 32'(obs_q.size()), 32'd0);
    stream = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    run_session("after_abort", 1'b0);

    // Abort coinciding with the write strobe: no write may be seen.
    stream = '{8'h00, 8'h02, 8'h56, 8'h78};
    start_session();
    send_stream(1'b0);
    abort = 1'b1;
    #1 check("abort_write_load", 32'(rom_load), 32'd0);
    @(negedge clk); abort = 1'b0;
    check("abort_write_nwrites", 32'(obs_q.size()), 32'd0);
    check("abort_write_hold", 32'(cpu_hold), 32'd0);

    // Reset while the second word's low byte is pending.
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    start_session();
    send_stream(1'b0);
    check("pre_rst_words", 32'(words_loaded), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_nwrites", 32'(obs_q.size()), 32'd1);
    stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    run_session("after_rst", 1'b0);

    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    run_session("backpressure", 1'b1);

    // N equal to the depth is accepted.
    stream = '{8'h40, 8'h00};
    start_session();
    send_stream(1'b0);
    check("max_n_ready", 32'(byte_ready), 32'd1);
    check("max_n_error", 32'(error), 32'd0);
    check("max_n_hold", 32'(cpu_hold), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("max_n_abort_hold", 32'(cpu_hold), 32'd0);

    for (int s = 0; s < 6; s++) begin
      stream.delete();
      n = $urandom_range(1, 7);
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom));
      run_session("random", 1'b1);
    end

    for (int s = 0; s < 2; s++) begin
      n = $urandom_range(DEPTH + 1, 65535);
      stream = '{8'(n >> 8), 8'(n)};
      run_session("random_err", 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
